sudoku_board_store: RTL
=======================

// Module: sudoku_board_store
// PURPOSE
//  Parametrised Sudoku board store for any box size (BOX=3 gives 9x9). Holds cell values plus
//  incrementally maintained row/column/box "used" masks, rejects writes that break Sudoku rules,
//  answers reads with the cell value and its candidate mask, and clears the board with a sweep FSM.
//  Sits between the solver controller (backtracking engine) and the display/flattened-board consumers.
// PARAMETERS
//  BOX  3  box edge; N=BOX*BOX symbols per row, CELLS=N*N (localparams, not overridable)
//  VW   4  value width; must satisfy 2**VW > N (0 = empty cell)
//  IW   7  cell index width; must satisfy 2**IW >= CELLS
// PORTS
//  clk          in   1        single clock, all state on rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  clear_start  in   1        pulse: start board clear sweep
//  busy         out  1        high while clear sweep runs
//  wr_en        in   1        write request (ignored while busy)
//  wr_idx       in   IW       row-major cell index (row*N+col)
//  wr_val       in   VW       value 1..N, or 0 = erase
//  wr_ack       out  1        pulse, 1 cycle after accepted write
//  wr_err       out  1        pulse, 1 cycle after rejected write
//  rd_en        in   1        read request (ignored while busy)
//  rd_idx       in   IW       cell to read
//  rd_valid     out  1        pulse, 1 cycle after rd_en
//  rd_val       out  VW       cell value
//  rd_cand      out  N        bit k set = value k+1 legal in cell; all 0 if cell filled
//  filled_count out  IW+1     number of non-zero cells
//  solved       out  1        filled_count == CELLS
//  board_flat   out  CELLS*VW cell i at [i*VW +: VW], combinational from storage
// BEHAVIOUR
//  - Reset (rst_n low, async): all cells 0, all masks 0, FSM IDLE, busy/wr_ack/wr_err/rd_valid 0,
//    rd_val 0, rd_cand 0, filled_count 0. Reset mid-sweep aborts the sweep; state is the same clean board.
//  - FSM IDLE -> CLEAR on clear_start; masks and filled_count zeroed on that edge; CLEAR writes 0
//    to one cell per cycle (counter 0..CELLS-1), then CLEAR -> IDLE. busy is high for exactly CELLS
//    cycles. clear_start while busy is ignored. Requests during busy produce no ack/err/valid.
//  - Write (IDLE), decision in the request cycle, result registered (1-cycle latency):
//    * wr_idx >= CELLS or wr_val > N -> wr_err, no state change.
//    * wr_val==0: if cell non-zero, clear bit (old-1) in its row/col/box masks, count-1; wr_ack
//      (erasing an empty cell also acks, no change).
//    * wr_val!=0 into non-empty cell -> wr_err (erase first; no implicit overwrite).
//    * wr_val!=0 into empty cell: if bit (v-1) set in row|col|box mask -> wr_err; else store,
//      set the three mask bits, count+1, wr_ack.
//    * wr_ack and wr_err are never high together.
//  - Read (IDLE): rd_val/rd_cand registered 1 cycle after rd_en using pre-edge state; a read and
//    write to the same cell in the same cycle return the OLD value/mask. rd_idx >= CELLS -> rd_val 0,
//    rd_cand 0, rd_valid still pulses. rd_val/rd_cand hold between reads.
//  - Geometry: row=idx/N, col=idx%N, box=(row/BOX)*BOX + col/BOX; computed without runtime
//    dividers (constant-divisor logic or small lookup generated from parameters).
// STRUCTURE
//  - Package sudoku_pkg: BOX/N/CELLS derivation helpers, clog2 function, FSM state encoding
//    (ST_IDLE, ST_CLEAR), geometry functions row_of/col_of/box_of.
//  - One sub-module: sudoku_cell_geom (combinational idx -> row, col, box, in_range), instantiated
//    twice (write port, read port). Masks as three N-entry arrays of N-bit vectors.
// TESTING
//  - Reset, then write idx 0 val 5 -> wr_ack next cycle; read idx 1 -> rd_val 0, rd_cand 9'h1EF.
//  - Write idx 8 val 5 (same row) -> wr_err; idx 72 val 5 (same col) -> wr_err; idx 10 val 5 (same box) -> wr_err.
//  - Write idx 0 val 3 over existing 5 -> wr_err; erase idx 0 then write val 3 -> wr_ack, count stays 1.
//  - wr_idx 81 or wr_val 10 (BOX=3) -> wr_err, board_flat unchanged; rd_idx 90 -> rd_valid, rd_val 0.
//  - Fill valid solved grid (81 writes) -> solved=1, filled_count=81; clear_start -> busy 81 cycles,
//    rd/wr during busy ignored, afterwards board_flat all 0, count 0.
//  - Assert rst_n low mid-sweep and mid-write -> all outputs 0 immediately; rerun with BOX=2 (4x4).

Source files
------------

// File: rtl/sudoku_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sudoku_pkg
//  Purpose  : Shared definitions for the Sudoku board store: size helpers,
//             clog2, clear-sweep state encoding and cell geometry functions.
//  Revision : 1.0 - initial release
// ============================================================================
package sudoku_pkg;

    // Board controller states: idle (serving requests) or clear sweep.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Ceiling log2, never less than 1 so it is usable as a vector width.
    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Symbols per row for a given box edge.
    function automatic int n_of(input int box);
        return box * box;
    endfunction

    // Total cells on the board for a given box edge.
    function automatic int cells_of(input int box);
        return n_of(box) * n_of(box);
    endfunction

    // Geometry helpers; only ever evaluated with elaboration-time constant
    // arguments, so no runtime divider is produced.
    function automatic int row_of(input int idx, input int box);
        return idx / n_of(box);
    endfunction

    function automatic int col_of(input int idx, input int box);
        return idx % n_of(box);
    endfunction

    function automatic int box_of(input int idx, input int box);
        return (row_of(idx, box) / box) * box + (col_of(idx, box) / box);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sudoku_cell_geom.sv
`default_nettype none
// ============================================================================
//  Module   : sudoku_cell_geom
//  Purpose  : Combinational cell index -> row / column / box decode with an
//             in-range flag, built as a constant lookup over all cells.
//  Revision : 1.0 - initial release
// ============================================================================
module sudoku_cell_geom
    import sudoku_pkg::*;
#(
    parameter  int BOX   = 3,
    parameter  int IW    = 7,
    localparam int N     = n_of(BOX),
    localparam int CELLS = cells_of(BOX),
    localparam int RW    = clog2(N)
) (
    input  logic [IW-1:0] idx,
    output logic [RW-1:0] row,
    output logic [RW-1:0] col,
    output logic [RW-1:0] box,
    output logic          in_range
);

    // Each loop iteration compares against a constant index and yields
    // constant coordinates, so this unrolls into a small lookup mux.
    always_comb begin
        row      = '0;
        col      = '0;
        box      = '0;
        in_range = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            if (idx == IW'(i)) begin
                row      = RW'(row_of(i, BOX));
                col      = RW'(col_of(i, BOX));
                box      = RW'(box_of(i, BOX));
                in_range = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sudoku_board_store.sv
`default_nettype none
// ============================================================================
//  Module   : sudoku_board_store
//  Purpose  : Sudoku cell storage with incrementally maintained row/column/
//             box used-masks, rule-checked writes, candidate reads and a
//             one-cell-per-cycle clear sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module sudoku_board_store
    import sudoku_pkg::*;
#(
    parameter  int BOX   = 3,
    parameter  int VW    = 4,
    parameter  int IW    = 7,
    localparam int N     = n_of(BOX),
    localparam int CELLS = cells_of(BOX)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_start,
    output logic                busy,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_idx,
    input  logic [VW-1:0]       wr_val,
    output logic                wr_ack,
    output logic                wr_err,
    input  logic                rd_en,
    input  logic [IW-1:0]       rd_idx,
    output logic                rd_valid,
    output logic [VW-1:0]       rd_val,
    output logic [N-1:0]        rd_cand,
    output logic [IW:0]         filled_count,
    output logic                solved,
    output logic [CELLS*VW-1:0] board_flat
);

    localparam int            RW          = clog2(N);
    localparam logic [IW-1:0] c_last_idx  = IW'(CELLS - 1);
    localparam logic [IW:0]   c_cells_cnt = (IW + 1)'(CELLS);
    localparam logic [VW-1:0] c_max_val   = VW'(N);

    // Storage
    state_t        r_state;
    logic          r_busy;
    logic [IW-1:0] r_clr_idx;
    logic [IW:0]   r_filled;
    logic [VW-1:0] r_cells    [CELLS];
    logic [N-1:0]  r_row_mask [N];
    logic [N-1:0]  r_col_mask [N];
    logic [N-1:0]  r_box_mask [N];

    // Write-port decode
    logic [RW-1:0] w_wr_row, w_wr_col, w_wr_box;
    logic          w_wr_in;
    logic [VW-1:0] w_wr_old;
    logic [N-1:0]  w_wr_used, w_new_bit, w_old_bit;
    logic          w_idle, w_wr_req, w_wr_legal, w_fill, w_erase, w_ack, w_err;

    // Read-port decode
    logic [RW-1:0] w_rd_row, w_rd_col, w_rd_box;
    logic          w_rd_in;
    logic [VW-1:0] w_rd_old;
    logic [N-1:0]  w_rd_used;
    logic          w_rd_req;

    sudoku_cell_geom #(.BOX(BOX), .IW(IW)) u_wr_geom (
        .idx      (wr_idx),
        .row      (w_wr_row),
        .col      (w_wr_col),
        .box      (w_wr_box),
        .in_range (w_wr_in)
    );

    sudoku_cell_geom #(.BOX(BOX), .IW(IW)) u_rd_geom (
        .idx      (rd_idx),
        .row      (w_rd_row),
        .col      (w_rd_col),
        .box      (w_rd_box),
        .in_range (w_rd_in)
    );

    assign w_wr_old  = w_wr_in ? r_cells[wr_idx] : '0;
    assign w_wr_used = r_row_mask[w_wr_row] | r_col_mask[w_wr_col] | r_box_mask[w_wr_box];
    assign w_rd_old  = w_rd_in ? r_cells[rd_idx] : '0;
    assign w_rd_used = r_row_mask[w_rd_row] | r_col_mask[w_rd_col] | r_box_mask[w_rd_box];

    // One-hot mask bits for the value being written and the value being erased.
    always_comb begin
        w_new_bit = '0;
        w_old_bit = '0;
        for (int k = 0; k < N; k++) begin
            w_new_bit[k] = (wr_val == VW'(k + 1));
            w_old_bit[k] = (w_wr_old == VW'(k + 1));
        end
    end

    // Write decision. A write in the same cycle as clear_start is dropped,
    // since the masks are being wiped on that edge.
    always_comb begin
        w_idle     = (r_state == ST_IDLE);
        w_wr_req   = wr_en && w_idle && !clear_start;
        w_wr_legal = w_wr_in && (wr_val <= c_max_val);
        w_erase    = w_wr_req && w_wr_legal && (wr_val == '0) && (w_wr_old != '0);
        w_fill     = w_wr_req && w_wr_legal && (wr_val != '0) && (w_wr_old == '0)
                     && !(|(w_wr_used & w_new_bit));
        w_ack      = w_wr_req && w_wr_legal && ((wr_val == '0) || w_fill);
        w_err      = w_wr_req && !w_ack;
        w_rd_req   = rd_en && w_idle;
    end

    // Board state and clear-sweep controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_clr_idx <= '0;
            r_filled  <= '0;
            for (int i = 0; i < CELLS; i++) r_cells[i] <= '0;
            for (int k = 0; k < N; k++) begin
                r_row_mask[k] <= '0;
                r_col_mask[k] <= '0;
                r_box_mask[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_start) begin
                        r_state   <= ST_CLEAR;
                        r_busy    <= 1'b1;
                        r_clr_idx <= '0;
                        r_filled  <= '0;
                        for (int k = 0; k < N; k++) begin
                            r_row_mask[k] <= '0;
                            r_col_mask[k] <= '0;
                            r_box_mask[k] <= '0;
                        end
                    end else if (w_fill) begin
                        r_cells[wr_idx]      <= wr_val;
                        r_row_mask[w_wr_row] <= r_row_mask[w_wr_row] | w_new_bit;
                        r_col_mask[w_wr_col] <= r_col_mask[w_wr_col] | w_new_bit;
                        r_box_mask[w_wr_box] <= r_box_mask[w_wr_box] | w_new_bit;
                        r_filled             <= r_filled + (IW + 1)'(1);
                    end else if (w_erase) begin
                        r_cells[wr_idx]      <= '0;
                        r_row_mask[w_wr_row] <= r_row_mask[w_wr_row] & ~w_old_bit;
                        r_col_mask[w_wr_col] <= r_col_mask[w_wr_col] & ~w_old_bit;
                        r_box_mask[w_wr_box] <= r_box_mask[w_wr_box] & ~w_old_bit;
                        r_filled             <= r_filled - (IW + 1)'(1);
                    end
                end
                ST_CLEAR: begin
                    r_cells[r_clr_idx] <= '0;
                    if (r_clr_idx == c_last_idx) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_idx <= r_clr_idx + IW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Registered write/read responses; read data uses the pre-edge board.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack   <= 1'b0;
            wr_err   <= 1'b0;
            rd_valid <= 1'b0;
            rd_val   <= '0;
            rd_cand  <= '0;
        end else begin
            wr_ack   <= w_ack;
            wr_err   <= w_err;
            rd_valid <= w_rd_req;
            if (w_rd_req) begin
                rd_val  <= w_rd_old;
                rd_cand <= (w_rd_in && (w_rd_old == '0)) ? ~w_rd_used : '0;
            end
        end
    end

    assign busy         = r_busy;
    assign filled_count = r_filled;
    assign solved       = (r_filled == c_cells_cnt);

    generate
        for (genvar gi = 0; gi < CELLS; gi++) begin : g_flat
            assign board_flat[gi*VW +: VW] = r_cells[gi];
        end
    endgenerate

endmodule
`default_nettype wire
